window_gen: RTL and testbench

//  Streaming window generator between the RAM-read DMA path and the conv/pool datapath.

---
 rtl/window_gen_if.sv | 38 +++
 rtl/window_gen.sv | 169 ++++++++++++++++
 tb/tb_window_gen.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/window_gen_if.sv
// -----------------------------------------------------------------------------
// window_gen_if
// Purpose : bundles the control, pixel-stream and window-stream signals of
//           window_gen so the generator and its producer/consumer share one port.
// Signals : start/image_size/pooling  job control (sampled on start)
//           pix_valid/pix_data/pix_ready  pixel input handshake
//           win_valid/win_data/win_ready  window output handshake
//           busy/done                     job status
// Modports: master = pixel source / window sink / controller
//           slave  = window_gen
// -----------------------------------------------------------------------------
interface window_gen_if #(
  parameter int DW = 16,
  parameter int K  = 5,
  parameter int SW = 5
);
  logic              start;
  logic [SW-1:0]     image_size;
  logic              pooling;
  logic              pix_valid;
  logic [DW-1:0]     pix_data;
  logic              pix_ready;
  logic              win_valid;
  logic              win_ready;
  logic [K*K*DW-1:0] win_data;
  logic              busy;
  logic              done;

  modport master (
    output start, image_size, pooling, pix_valid, pix_data, win_ready,
    input  pix_ready, win_valid, win_data, busy, done
  );

  modport slave (
    input  start, image_size, pooling, pix_valid, pix_data, win_ready,
    output pix_ready, win_valid, win_data, busy, done
  );
endinterface

// File: rtl/window_gen.sv
// -----------------------------------------------------------------------------
// window_gen
// Purpose : streaming window generator. Takes one pixel per handshake in raster
//           order and emits KxK stride-1 conv windows, or 2x2 stride-2 pool
//           windows packed into the top-left corner of the KxK bus.
//           K-1 line buffers feed a KxK shift array; a single output register
//           carries the window, and pixels stall while it is held.
// Ports   : clk  rising-edge clock
//           rst  synchronous active-high reset
//           bus  window_gen_if.slave (control, pixel and window handshakes)
// -----------------------------------------------------------------------------
module window_gen #(
  parameter int DW   = 16,
  parameter int MAXN = 32,
  parameter int K    = 5
) (
  input  logic         clk,
  input  logic         rst,
  window_gen_if.slave  bus
);
  localparam int CW = $clog2(MAXN);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

  state_t              r_state, w_state_nxt;
  logic [CW:0]         r_n;
  logic                r_pool;
  logic [CW-1:0]       r_row, r_col;
  logic [DW-1:0]       r_lb  [K-1][MAXN];
  logic [DW-1:0]       r_arr [K][K];
  logic [DW-1:0]       w_arr_nxt [K][K];
  logic                r_win_valid;
  logic [K*K*DW-1:0]   r_win_data, w_win_pack;
  logic                w_pix_ready, w_busy, w_done;
  logic                w_accept, w_last_col, w_last_pix, w_qualify;

  assign w_accept   = bus.pix_valid && w_pix_ready;
  assign w_last_col = ({1'b0, r_col} == r_n - (CW+1)'(1));
  assign w_last_pix = w_last_col && ({1'b0, r_row} == r_n - (CW+1)'(1));
  // The accepted pixel is the bottom-right element of the candidate window.
  assign w_qualify  = r_pool ? (r_row[0] && r_col[0])
                             : (r_row >= CW'(K-1) && r_col >= CW'(K-1));

  // ---------------- FSM: state register ----------------
  // NOTE: sequential state is written only with non-blocking assignments so
  // every flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // ---------------- FSM: next state ----------------
  // NOTE: every combinational output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.start)                      w_state_nxt = S_RUN;
      S_RUN:   if (w_accept && w_last_pix)         w_state_nxt = S_FLUSH;
      S_FLUSH: if (!r_win_valid || bus.win_ready)  w_state_nxt = S_DONE;
      S_DONE:                                      w_state_nxt = S_IDLE;
      default:                                     w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    w_pix_ready = 1'b0;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      // A pixel may only enter when the output register is free or being
      // drained this cycle, so backpressure is pixel-for-pixel.
      S_RUN:   begin
                 w_pix_ready = !r_win_valid || bus.win_ready;
                 w_busy      = 1'b1;
               end
      S_FLUSH: w_busy = 1'b1;
      S_DONE:  w_done = 1'b1;
      default: ;
    endcase
  end

  assign bus.pix_ready = w_pix_ready;
  assign bus.busy      = w_busy;
  assign bus.done      = w_done;
  assign bus.win_valid = r_win_valid;
  assign bus.win_data  = r_win_data;

  // ---------------- configuration and raster counters ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_n    <= '0;
      r_pool <= 1'b0;
      r_row  <= '0;
      r_col  <= '0;
    end else if (r_state == S_IDLE && bus.start) begin
      // A size of 0 encodes the maximum image side.
      r_n    <= (bus.image_size == '0) ? (CW+1)'(MAXN) : {1'b0, bus.image_size};
      r_pool <= bus.pooling;
      r_row  <= '0;
      r_col  <= '0;
    end else if (w_accept) begin
      if (w_last_col) begin
        r_col <= '0;
        r_row <= r_row + CW'(1);
      end else begin
        r_col <= r_col + CW'(1);
      end
    end
  end

  // ---------------- shift array next value ----------------
  // Shift left one column and insert the new column: oldest line buffer at
  // the top row, the incoming pixel at the bottom.
  always_comb begin
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K-1; c++)
        w_arr_nxt[r][c] = r_arr[r][c+1];
    for (int r = 0; r < K-1; r++)
      w_arr_nxt[r][K-1] = r_lb[K-2-r][r_col];
    w_arr_nxt[K-1][K-1] = bus.pix_data;
  end

  // Pack the post-shift array: full KxK in conv mode, bottom-right 2x2 in pool.
  always_comb begin
    w_win_pack = '0;
    if (r_pool) begin
      w_win_pack[0*DW     +: DW] = w_arr_nxt[K-2][K-2];
      w_win_pack[1*DW     +: DW] = w_arr_nxt[K-2][K-1];
      w_win_pack[K*DW     +: DW] = w_arr_nxt[K-1][K-2];
      w_win_pack[(K+1)*DW +: DW] = w_arr_nxt[K-1][K-1];
    end else begin
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++)
          w_win_pack[(r*K+c)*DW +: DW] = w_arr_nxt[r][c];
    end
  end

  // ---------------- line buffers and shift array ----------------
  // NOTE: storage arrays are not reset; windows only qualify once every
  // element has been refilled from the current image, so stale data never
  // reaches the output.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_lb[0][r_col] <= bus.pix_data;
      for (int i = 1; i < K-1; i++)
        r_lb[i][r_col] <= r_lb[i-1][r_col];
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++)
          r_arr[r][c] <= w_arr_nxt[r][c];
    end
  end

  // ---------------- output register ----------------
  // A new window may overwrite one that is being consumed in the same cycle,
  // giving back-to-back windows with no bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_win_valid <= 1'b0;
      r_win_data  <= '0;
    end else if (w_accept && w_qualify) begin
      r_win_valid <= 1'b1;
      r_win_data  <= w_win_pack;
    end else if (bus.win_ready) begin
      r_win_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_window_gen.sv
// -----------------------------------------------------------------------------
// tb_window_gen
// Purpose : self-checking bench for window_gen. The driver pushes the windows
//           each image should produce into a queue; an independent monitor pops
//           and compares whenever a window handshake completes.
// -----------------------------------------------------------------------------
module tb_window_gen;
  localparam int DW = 16;
  localparam int K  = 5;
  localparam int WW = K*K*DW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  window_gen_if #(.DW(DW), .K(K), .SW(5)) bus ();

  window_gen #(.DW(DW), .MAXN(32), .K(K)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int            checks = 0;
  int            errors = 0;
  logic [WW-1:0] exp_q[$];
  int            win_cnt  = 0;
  int            done_cnt = 0;
  bit            rdy_mode = 1'b0;
  bit            tgl      = 1'b0;
  bit            prev_stall = 1'b0;
  logic [WW-1:0] prev_data;

  task automatic check(input string name, input logic [WW-1:0] got,
                       input logic [WW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, got, exp);
    end
  endtask

  // Conv window with top-left at image (i,j); pixel value = raster index.
  function automatic logic [WW-1:0] conv_win(int n, int i, int j);
    logic [WW-1:0] v = '0;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        v[(r*K+c)*DW +: DW] = DW'((i+r)*n + (j+c));
    return v;
  endfunction

  // Pool window number (i,j): 2x2 block at image (2i,2j) in the top-left corner.
  function automatic logic [WW-1:0] pool_win(int n, int i, int j);
    logic [WW-1:0] v = '0;
    v[0*DW     +: DW] = DW'((2*i)*n   + 2*j);
    v[1*DW     +: DW] = DW'((2*i)*n   + 2*j + 1);
    v[K*DW     +: DW] = DW'((2*i+1)*n + 2*j);
    v[(K+1)*DW +: DW] = DW'((2*i+1)*n + 2*j + 1);
    return v;
  endfunction

  // Consumer ready: always 1, or alternating 1010... in backpressure mode.
  initial begin
    forever begin
      @(negedge clk);
      tgl = !tgl;
      bus.win_ready = rdy_mode ? tgl : 1'b1;
    end
  end

  // Monitor: samples 4 time units after the falling edge (1 before rising).
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) check("hold_data", bus.win_data, prev_data);
        if (bus.win_valid && !bus.win_ready)
          check("blocked_pix_ready", WW'(bus.pix_ready), WW'(0));
        if (bus.win_valid && bus.win_ready) begin
          win_cnt++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_window got %h exp none", bus.win_data);
          end else begin
            check("window", bus.win_data, exp_q.pop_front());
          end
        end
        if (bus.done) done_cnt++;
        prev_stall = bus.win_valid && !bus.win_ready;
        prev_data  = bus.win_data;
      end
    end
  end

  task automatic check_idle_outputs(input string tag);
    check({tag, "_pix_ready"}, WW'(bus.pix_ready), WW'(0));
    check({tag, "_win_valid"}, WW'(bus.win_valid), WW'(0));
    check({tag, "_win_data"},  bus.win_data,       WW'(0));
    check({tag, "_busy"},      WW'(bus.busy),      WW'(0));
    check({tag, "_done"},      WW'(bus.done),      WW'(0));
  endtask

  // Runs one image. abort_after >= 0 asserts rst before that pixel index.
  task automatic run_image(input int n_cfg, input bit pool, input bit toggle,
                           input int abort_after, input bit chk_lat);
    int n = (n_cfg == 0) ? 32 : n_cfg;
    int tot = n * n;
    int nexp;
    int base;
    int b;
    bit acc;

    if (!pool) begin
      for (int i = 0; i <= n-5; i++)
        for (int j = 0; j <= n-5; j++)
          exp_q.push_back(conv_win(n, i, j));
    end else begin
      for (int i = 0; i < n/2; i++)
        for (int j = 0; j < n/2; j++)
          exp_q.push_back(pool_win(n, i, j));
    end
    nexp     = exp_q.size();
    win_cnt  = 0;
    base     = done_cnt;
    rdy_mode = toggle;

    @(negedge clk);
    bus.image_size = 5'(n_cfg);
    bus.pooling    = pool;
    bus.start      = 1'b1;
    @(negedge clk);
    bus.start      = 1'b0;
    bus.image_size = ~5'(n_cfg);   // must not affect the running job
    bus.pooling    = !pool;
    #3;
    check("busy_after_start", WW'(bus.busy), WW'(1));

    for (int p = 0; p < tot; p++) begin
      @(negedge clk);
      if (abort_after >= 0 && p == abort_after) begin
        bus.pix_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #3;
        check_idle_outputs("after_rst");
        exp_q.delete();
        rdy_mode = 1'b0;
        return;
      end
      bus.pix_valid = 1'b1;
      bus.pix_data  = DW'(p);
      bus.start     = (p == 3);    // start while busy must be ignored
      acc = 1'b0;
      b   = 0;
      while (!acc) begin
        #3;
        if (bus.pix_valid && bus.pix_ready) begin
          acc = 1'b1;
        end else begin
          b++;
          if (b > 200) begin
            checks++;
            errors++;
            $display("FAIL pix_accept_timeout got pixel %0d exp accepted", p);
            bus.pix_valid = 1'b0;
            bus.start     = 1'b0;
            return;
          end
          @(negedge clk);
        end
      end
    end

    @(negedge clk);
    bus.pix_valid = 1'b0;
    bus.start     = 1'b0;
    if (chk_lat) begin
      #3;
      check("latency_win_valid", WW'(bus.win_valid), WW'(1));
    end

    b = 0;
    while (!bus.done && b <= 200) begin
      @(negedge clk);
      #3;
      b++;
    end
    if (b > 200) begin
      checks++;
      errors++;
      $display("FAIL done_timeout got no done exp done pulse");
    end
    @(negedge clk);
    #3;
    check("done_pulses",     WW'(done_cnt - base),  WW'(1));
    check("done_low_after",  WW'(bus.done),         WW'(0));
    check("busy_after_done", WW'(bus.busy),         WW'(0));
    check("window_count",    WW'(win_cnt),          WW'(nexp));
    check("queue_empty",     WW'(exp_q.size()),     WW'(0));
    rdy_mode = 1'b0;
  endtask

  initial begin
    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.image_size = '0;
    bus.pooling    = 1'b0;
    bus.pix_valid  = 1'b0;
    bus.pix_data   = '0;
    bus.win_ready  = 1'b1;

    repeat (3) @(negedge clk);
    #3;
    check_idle_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    run_image(5,  1'b0, 1'b0, -1, 1'b1);  // single conv window, latency check
    run_image(7,  1'b0, 1'b0, -1, 1'b0);  // 9 conv windows, row-edge isolation
    run_image(6,  1'b1, 1'b0, -1, 1'b0);  // 9 pool windows
    run_image(5,  1'b1, 1'b0, -1, 1'b0);  // odd N pool: 4 windows
    run_image(8,  1'b0, 1'b1, -1, 1'b0);  // backpressure: 16 windows
    run_image(3,  1'b0, 1'b0, -1, 1'b0);  // degenerate conv: no windows
    run_image(0,  1'b1, 1'b0, -1, 1'b0);  // N=0 -> 32, 256 pool windows
    run_image(10, 1'b0, 1'b0, 30, 1'b0);  // reset mid-image
    run_image(5,  1'b0, 1'b0, -1, 1'b1);  // clean restart after reset

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
